// File: rtl/word_memory_bank.sv
// Register-file bank of DEPTH words with a one-cycle registered read port and a
// multi-cycle clear sweep that zeroes one word per clock.
module word_memory_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    addr,
  input  logic             store,
  input  logic             clear,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] memory,
  output logic [WIDTH-1:0] n_mem,
  output logic             busy,
  output logic             clr_done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                      state, state_d;
  logic [AW-1:0]               idx, idx_d;
  logic                        done_d;
  logic                        wr_en;
  logic [DEPTH-1:0][WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0]            rd_next;

  // clear outranks store, and nothing is written while a sweep runs
  assign wr_en = (state == IDLE) && store && !clear;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic zero_hit, wr_hit;
    assign zero_hit  = (state == SWEEP) && (idx == AW'(i));
    assign wr_hit    = wr_en && (addr == AW'(i));
    assign word_d[i] = zero_hit ? '0 : (wr_hit ? data : word_q[i]);
  end

  // Reading the post-edge value gives write and sweep forwarding for free;
  // addresses past DEPTH match no word and read zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == AW'(i)) rd_next = word_d[i];
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      clr_done <= 1'b0;
      word_q   <= '0;
      memory   <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      clr_done <= done_d;
      word_q   <= word_d;
      memory   <= rd_next;
    end
  end

  assign busy  = (state == SWEEP);
  assign n_mem = ~memory;

endmodule
